// File: rtl/mesm6_pkg.sv
// Shared types for the mesm6 instruction fetch path.
package mesm6_pkg;

  typedef logic [23:0] insn_t;
  typedef logic [47:0] word_t;
  typedef logic [14:0] iaddr_t;

  typedef enum logic [1:0] {StIdle, StReq, StGap} ifetch_state_t;

  // Left half (47:24) executes before right half (23:0).
  function automatic insn_t insn_half(word_t w, logic right);
    return right ? w[23:0] : w[47:24];
  endfunction

endpackage

// File: rtl/mesm6_ififo.sv
// Prefetch FIFO of 48-bit instruction words with synchronous flush.
module mesm6_ififo
  import mesm6_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  flush_i,
  input  logic  push_i,
  input  word_t wdata_i,
  input  logic  pop_i,
  output word_t rdata_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = PtrW + 1;

  word_t           mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      // Simultaneous push and pop leaves the count unchanged.
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/mesm6_ifetch.sv
// Instruction fetch: reads 48-bit words from imemory, prefetches them and
// hands out two 24-bit instructions per word, with jump redirect.
module mesm6_ifetch
  import mesm6_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 15
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_jump,
  input  logic [AW-1:0] i_jump_pc,
  input  logic          i_jump_right,
  output logic [AW-1:0] o_imem_addr,
  output logic          o_imem_read,
  input  word_t         i_imem_data,
  input  logic          i_imem_done,
  output insn_t         o_insn,
  output logic [AW-1:0] o_pc,
  output logic          o_right,
  output logic          o_valid,
  input  logic          i_ready
);

  ifetch_state_t state_q;
  logic [AW-1:0] fetch_ptr_q;
  logic [AW-1:0] pc_q;
  logic          read_q;
  logic          half_q;

  word_t head;
  logic  fifo_full, fifo_empty;
  logic  accept, push, pop;

  assign accept = ~fifo_empty & i_ready;
  // A jump discards any word completing in the same cycle and overrides accept.
  assign push   = (state_q == StReq) & i_imem_done & ~i_jump;
  assign pop    = accept & half_q & ~i_jump;

  mesm6_ififo #(
    .Depth(DEPTH)
  ) u_ififo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush_i (i_jump),
    .push_i  (push),
    .wdata_i (i_imem_data),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      read_q      <= 1'b0;
      fetch_ptr_q <= '0;
      pc_q        <= '0;
      half_q      <= 1'b0;
    end else if (i_jump) begin
      state_q     <= StGap;
      read_q      <= 1'b0;
      fetch_ptr_q <= i_jump_pc;
      pc_q        <= i_jump_pc;
      half_q      <= i_jump_right;
    end else begin
      case (state_q)
        StIdle: begin
          // Nothing is in flight here, so a free slot is simply "not full".
          if (!fifo_full) begin
            state_q <= StReq;
            read_q  <= 1'b1;
          end
        end
        StReq: begin
          if (i_imem_done) begin
            state_q     <= StGap;
            read_q      <= 1'b0;
            fetch_ptr_q <= fetch_ptr_q + AW'(1);
          end
        end
        StGap: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          read_q  <= 1'b0;
        end
      endcase

      if (accept) begin
        if (half_q) begin
          half_q <= 1'b0;
          pc_q   <= pc_q + AW'(1);
        end else begin
          half_q <= 1'b1;
        end
      end
    end
  end

  assign o_imem_read = read_q;
  assign o_imem_addr = fetch_ptr_q;
  assign o_valid     = ~fifo_empty;
  assign o_insn      = o_valid ? insn_half(head, half_q) : '0;
  assign o_pc        = pc_q;
  assign o_right     = half_q;

endmodule

// File: tb/tb_mesm6_ifetch.sv
// Scoreboard bench for mesm6_ifetch with a 2-cycle-latency imemory model.
module tb_mesm6_ifetch;
  import mesm6_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned AW    = 15;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_jump = 1'b0;
  logic [AW-1:0] i_jump_pc = '0;
  logic          i_jump_right = 1'b0;
  logic          i_ready = 1'b0;
  logic [AW-1:0] o_imem_addr;
  logic          o_imem_read;
  word_t         i_imem_data;
  logic          i_imem_done;
  insn_t         o_insn;
  logic [AW-1:0] o_pc;
  logic          o_right;
  logic          o_valid;

  typedef struct packed {
    insn_t         insn;
    logic [AW-1:0] pc;
    logic          right;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  always #5 clk = ~clk;

  mesm6_ifetch #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_jump      (i_jump),
    .i_jump_pc   (i_jump_pc),
    .i_jump_right(i_jump_right),
    .o_imem_addr (o_imem_addr),
    .o_imem_read (o_imem_read),
    .i_imem_data (i_imem_data),
    .i_imem_done (i_imem_done),
    .o_insn      (o_insn),
    .o_pc        (o_pc),
    .o_right     (o_right),
    .o_valid     (o_valid),
    .i_ready     (i_ready)
  );

  function automatic word_t mem_word(logic [AW-1:0] a);
    return {8'hA0, 1'b0, a, 8'hB0, 1'b0, a};
  endfunction

  // imemory: done on the third consecutive cycle of a held read.
  logic rd_d1 = 1'b0;
  logic rd_d2 = 1'b0;
  always @(posedge clk) begin
    rd_d1 <= o_imem_read;
    rd_d2 <= rd_d1 & o_imem_read;
  end
  assign i_imem_done = o_imem_read & rd_d2;
  assign i_imem_data = i_imem_done ? mem_word(o_imem_addr) : 48'h5A5A_DEAD_BEEF;

  // Monitor: scoreboard on accepts, read-hold and read-length checks.
  logic          prev_read = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  int            plen = 0;
  logic          aborted = 1'b0;
  always @(negedge clk) begin
    exp_t got;
    exp_t e;
    if (reset_n && !i_jump && o_valid && i_ready) begin
      got = '{insn: o_insn, pc: o_pc, right: o_right};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL insn_unexpected: got insn=%h pc=%h right=%b, required none",
                 o_insn, o_pc, o_right);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL insn_stream: got insn=%h pc=%h right=%b, required insn=%h pc=%h right=%b",
                   got.insn, got.pc, got.right, e.insn, e.pc, e.right);
        end
      end
    end
    if (o_imem_read === 1'b1 && i_imem_done === 1'b1 && !i_jump) done_cnt++;
    if (o_imem_read === 1'b1) begin
      if (prev_read === 1'b1) begin
        checks++;
        if (o_imem_addr !== prev_addr) begin
          errors++;
          $display("FAIL addr_hold: got %h, required %h", o_imem_addr, prev_addr);
        end
      end else begin
        plen = 0;
        aborted = 1'b0;
      end
      plen++;
      if (i_jump || !reset_n) aborted = 1'b1;
    end else if (prev_read === 1'b1 && !aborted) begin
      checks++;
      if (plen != 3) begin
        errors++;
        $display("FAIL read_len: got %0d cycles, required 3", plen);
      end
    end
    prev_read = o_imem_read;
    prev_addr = o_imem_addr;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic push_seq(input logic [AW-1:0] pc0, input logic right0, input int n);
    logic [AW-1:0] pc;
    logic          right;
    word_t         w;
    exp_t          e;
    pc = pc0;
    right = right0;
    for (int i = 0; i < n; i++) begin
      w = mem_word(pc);
      e.insn  = right ? w[23:0] : w[47:24];
      e.pc    = pc;
      e.right = right;
      exp_q.push_back(e);
      if (right) begin
        pc = pc + AW'(1);
        right = 1'b0;
      end else begin
        right = 1'b1;
      end
    end
  endtask

  task automatic do_jump(input logic [AW-1:0] pc, input logic right);
    i_jump = 1'b1;
    i_jump_pc = pc;
    i_jump_right = right;
    exp_q.delete();
    @(posedge clk);
    #1;
    i_jump = 1'b0;
    chk("valid_after_jump", 64'(o_valid), 64'd0);
  endtask

  task automatic drain();
    i_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    i_ready = 1'b0;
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic wait_read(input logic level);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (o_imem_read === level) begin
        seen = 1'b1;
        break;
      end
    end
    chk("wait_read", 64'(seen), 64'd1);
  endtask

  task automatic chk_all_zero();
    chk("rst_read", 64'(o_imem_read), 64'd0);
    chk("rst_addr", 64'(o_imem_addr), 64'd0);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_insn", 64'(o_insn), 64'd0);
    chk("rst_pc", 64'(o_pc), 64'd0);
    chk("rst_right", 64'(o_right), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    word_t w;
    logic  seen;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero();

    // Sequential run from word 0.
    reset_n = 1'b1;
    push_seq(15'h0000, 1'b0, 8);
    drain();

    // Stall: only DEPTH words fetched, then memory goes quiet.
    do_jump(15'h0100, 1'b0);
    done_cnt = 0;
    repeat (20) @(posedge clk);
    #1;
    chk("stall_words", 64'(done_cnt), 64'(DEPTH));
    chk("stall_read", 64'(o_imem_read), 64'd0);
    chk("stall_valid", 64'(o_valid), 64'd1);
    w = mem_word(15'h0100);
    chk("stall_head", 64'(o_insn), 64'(w[47:24]));
    chk("stall_pc", 64'(o_pc), 64'h100);
    push_seq(15'h0100, 1'b0, 8);
    drain();

    // Jump on the cycle a read completes; the completing word is dropped.
    do_jump(15'h0050, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (i_imem_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    chk("wait_done", 64'(seen), 64'd1);
    do_jump(15'h1234, 1'b1);
    push_seq(15'h1234, 1'b1, 5);
    drain();

    // Address wrap at the top of memory.
    do_jump(15'h7FFF, 1'b0);
    wait_read(1'b1);
    chk("wrap_addr_first", 64'(o_imem_addr), 64'h7FFF);
    wait_read(1'b0);
    wait_read(1'b1);
    chk("wrap_addr_next", 64'(o_imem_addr), 64'h0000);
    push_seq(15'h7FFF, 1'b0, 4);
    drain();

    // One-cycle reset in the middle of a read.
    do_jump(15'h0020, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (o_imem_read === 1'b1 && i_imem_done === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    chk("wait_req", 64'(seen), 64'd1);
    reset_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk_all_zero();
    reset_n = 1'b1;
    push_seq(15'h0000, 1'b0, 4);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
